// File: rtl/ps2_command_out.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send, shifts one
// command byte plus odd parity on device clock falling edges, then checks the device ACK.
module ps2_command_out #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] command,
    input  logic       send_command,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_timeout,
    output logic       error_no_ack
);
    localparam int TMR_MAX = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
    localparam int TW      = $clog2(TMR_MAX + 1);
    localparam int XW      = $clog2(XFER_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_INHIBIT, ST_REQ, ST_WAIT_FIRST,
        ST_SEND, ST_WAIT_ACK, ST_WAIT_IDLE, ST_ERR_TO
    } state_t;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    // Frame position 0..7 = data LSB-first, 8 = parity, 9 = stop (line released).
    function automatic logic frame_bit(input logic [7:0] data, input logic par,
                                       input logic [3:0] idx);
        logic b;
        case (idx)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: b = data[idx[2:0]];
            4'd8:    b = par;
            default: b = 1'b1;
        endcase
        return b;
    endfunction

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [XW-1:0]   xfer_q, xfer_d;
    logic [3:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      cmd_q, cmd_d;
    logic            parity_q, parity_d;
    logic            ack_ok_q, ack_ok_d;
    logic            clk_oe_q, clk_oe_d;
    logic            dat_oe_q, dat_oe_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_to_q, err_to_d;
    logic            no_ack_q, no_ack_d;
    logic            clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d, clk_prev_q, clk_prev_d;
    logic            dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
    logic            fe_s;
    logic            xfer_expired_s;
    logic            pulse_any_s;

    assign fe_s           = clk_prev_q & ~clk_sync_q;
    assign xfer_expired_s = (xfer_q == XW'(XFER_TIMEOUT - 1));
    // A request arriving in a status-pulse cycle belongs to the finished transfer and is dropped.
    assign pulse_any_s    = done_q | err_to_q | no_ack_q;

    assign ps2_clk_oe       = clk_oe_q;
    assign ps2_dat_oe       = dat_oe_q;
    assign busy             = busy_q;
    assign command_was_sent = done_q;
    assign error_timeout    = err_to_q;
    assign error_no_ack     = no_ack_q;

    // Next-state, counters and registered-output values.
    always_comb begin
        clk_meta_d = ps2_clk_in;
        clk_sync_d = clk_meta_q;
        clk_prev_d = clk_sync_q;
        dat_meta_d = ps2_dat_in;
        dat_sync_d = dat_meta_q;
        state_d    = state_q;
        timer_d    = timer_q;
        xfer_d     = xfer_q;
        bit_idx_d  = bit_idx_q;
        cmd_d      = cmd_q;
        parity_d   = parity_q;
        ack_ok_d   = ack_ok_q;
        dat_oe_d   = dat_oe_q;
        done_d     = 1'b0;
        err_to_d   = 1'b0;
        no_ack_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d   = '0;
                xfer_d    = '0;
                bit_idx_d = 4'd0;
                dat_oe_d  = 1'b0;
                if (send_command && !pulse_any_s) begin
                    state_d  = ST_INHIBIT;
                    cmd_d    = command;
                    parity_d = odd_parity(command);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INHIBIT: begin
                if (timer_q == TW'(INHIBIT_CYCLES - 1)) begin
                    state_d  = ST_REQ;
                    timer_d  = '0;
                    dat_oe_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_REQ: begin
                state_d  = ST_WAIT_FIRST;
                timer_d  = '0;
                dat_oe_d = 1'b1;
            end
            ST_WAIT_FIRST: begin
                if (fe_s) begin
                    state_d   = ST_SEND;
                    dat_oe_d  = ~frame_bit(cmd_q, parity_q, 4'd0);
                    bit_idx_d = 4'd1;
                    xfer_d    = '0;
                end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
                    state_d  = ST_ERR_TO;
                    dat_oe_d = 1'b0;
                end else begin
                    timer_d  = timer_q + TW'(1);
                    dat_oe_d = 1'b1;
                end
            end
            ST_SEND: begin
                if (xfer_expired_s) begin
                    state_d  = ST_ERR_TO;
                    dat_oe_d = 1'b0;
                end else begin
                    xfer_d = xfer_q + XW'(1);
                    if (fe_s) begin
                        dat_oe_d  = ~frame_bit(cmd_q, parity_q, bit_idx_q);
                        bit_idx_d = bit_idx_q + 4'd1;
                        if (bit_idx_q == 4'd9) begin
                            state_d = ST_WAIT_ACK;
                        end else begin
                            state_d = ST_SEND;
                        end
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (xfer_expired_s) begin
                    state_d  = ST_ERR_TO;
                    dat_oe_d = 1'b0;
                end else begin
                    xfer_d = xfer_q + XW'(1);
                    if (fe_s) begin
                        state_d  = ST_WAIT_IDLE;
                        ack_ok_d = ~dat_sync_q;
                    end else begin
                        state_d = ST_WAIT_ACK;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (xfer_expired_s) begin
                    state_d  = ST_ERR_TO;
                    dat_oe_d = 1'b0;
                end else begin
                    xfer_d = xfer_q + XW'(1);
                    if (clk_sync_q && dat_sync_q) begin
                        state_d  = ST_IDLE;
                        done_d   = ack_ok_q;
                        no_ack_d = ~ack_ok_q;
                    end else begin
                        state_d = ST_WAIT_IDLE;
                    end
                end
            end
            ST_ERR_TO: begin
                state_d  = ST_IDLE;
                dat_oe_d = 1'b0;
                err_to_d = 1'b1;
            end
            default: begin
                state_d  = ST_IDLE;
                dat_oe_d = 1'b0;
            end
        endcase
        // Outputs follow the next state so they change on the same edge as the state.
        clk_oe_d = (state_d == ST_INHIBIT) || (state_d == ST_REQ);
        busy_d   = (state_d != ST_IDLE);
    end

    // State, synchronizer and output registers with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            xfer_q     <= '0;
            bit_idx_q  <= 4'd0;
            cmd_q      <= 8'd0;
            parity_q   <= 1'b0;
            ack_ok_q   <= 1'b0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_to_q   <= 1'b0;
            no_ack_q   <= 1'b0;
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            xfer_q     <= xfer_d;
            bit_idx_q  <= bit_idx_d;
            cmd_q      <= cmd_d;
            parity_q   <= parity_d;
            ack_ok_q   <= ack_ok_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_to_q   <= err_to_d;
            no_ack_q   <= no_ack_d;
            clk_meta_q <= clk_meta_d;
            clk_sync_q <= clk_sync_d;
            clk_prev_q <= clk_prev_d;
            dat_meta_q <= dat_meta_d;
            dat_sync_q <= dat_sync_d;
        end
    end
endmodule

// File: tb/tb_ps2_command_out.sv
// Bench for ps2_command_out: a device model clocks frames out of the DUT over wired-AND
// pads and compares them with frames built from the byte, plus timeout and reset cases.
module tb_ps2_command_out;
    localparam int INH = 50;
    localparam int STO = 200;
    localparam int XTO = 2000;

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic [7:0] command;
    logic       send_command;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       busy, command_was_sent, error_timeout, error_no_ack;
    logic       bfm_clk_low = 1'b0;
    logic       bfm_dat_low = 1'b0;
    logic       prev_done, prev_noack, prev_to;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_noack  = 0;
    int n_to     = 0;
    int cyc      = 0;

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Open-collector pads: low if either side pulls.
    assign ps2_clk_in = ~(ps2_clk_oe | bfm_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | bfm_dat_low);

    ps2_command_out #(
        .INHIBIT_CYCLES(INH), .START_TIMEOUT(STO), .XFER_TIMEOUT(XTO)
    ) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .command(command), .send_command(send_command),
        .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .busy(busy),
        .command_was_sent(command_was_sent), .error_timeout(error_timeout),
        .error_no_ack(error_no_ack)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // Expected wire frame: 8 data bits LSB-first, odd parity, released stop bit.
    function automatic logic [9:0] model_frame(input logic [7:0] c);
        logic [9:0] f;
        f[7:0] = c;
        f[8]   = (($countones(c) % 2) == 0);
        f[9]   = 1'b1;
        return f;
    endfunction

    // Status pulses: counted, must be one cycle wide and coincide with busy low.
    always @(negedge CLOCK_50) begin
        if (command_was_sent === 1'b1) begin
            n_done++;
            check_eq("done_width", 32'(prev_done), 32'd0);
            check_eq("done_busy", 32'(busy), 32'd0);
        end
        if (error_no_ack === 1'b1) begin
            n_noack++;
            check_eq("noack_width", 32'(prev_noack), 32'd0);
            check_eq("noack_busy", 32'(busy), 32'd0);
        end
        if (error_timeout === 1'b1) begin
            n_to++;
            check_eq("to_width", 32'(prev_to), 32'd0);
            check_eq("to_busy", 32'(busy), 32'd0);
        end
        prev_done  = command_was_sent;
        prev_noack = error_no_ack;
        prev_to    = error_timeout;
    end

    task automatic start_send(input logic [7:0] c);
        command      = c;
        send_command = 1'b1;
        tick(1);
        send_command = 1'b0;
        check_eq("accept_busy", 32'(busy), 32'd1);
        check_eq("accept_clk_oe", 32'(ps2_clk_oe), 32'd1);
    endtask

    task automatic wait_release();
        for (int k = 0; k < INH + 20 && ps2_clk_oe; k++) tick(1);
        check_eq("clk_release", 32'(ps2_clk_oe), 32'd0);
        check_eq("start_bit", 32'(ps2_dat_oe), 32'd1);
    endtask

    // Device generates nclk clock pulses; data sampled while clock is low, just before it rises.
    task automatic device_frame(input int hp, input int nclk, input bit ack,
                                output logic [9:0] bits);
        bits = '1;
        for (int i = 1; i <= nclk; i++) begin
            if (i == 11) begin
                bfm_dat_low = ack;
                tick(hp / 2);
            end
            bfm_clk_low = 1'b1;
            tick(hp);
            if (i <= 10) bits[i-1] = ~ps2_dat_oe;
            bfm_clk_low = 1'b0;
            tick(hp);
        end
        bfm_dat_low = 1'b0;
    endtask

    task automatic run_transfer(input logic [7:0] c, input int hp, input bit ack,
                                input bit inject);
        int d0, a0, t0;
        logic [9:0] bits;
        d0 = n_done; a0 = n_noack; t0 = n_to;
        start_send(c);
        wait_release();
        tick(10);
        fork
            device_frame(hp, 11, ack, bits);
            begin
                if (inject) begin
                    tick(hp * 5);
                    command      = 8'h55;
                    send_command = 1'b1;
                    tick(1);
                    send_command = 1'b0;
                end
            end
        join
        for (int k = 0; k < hp * 4 && (n_done + n_noack + n_to) == (d0 + a0 + t0); k++) tick(1);
        tick(2);
        check_eq($sformatf("frame_%02h", c), 32'(bits), 32'(model_frame(c)));
        check_eq("done_cnt", n_done - d0, ack ? 32'd1 : 32'd0);
        check_eq("noack_cnt", n_noack - a0, ack ? 32'd0 : 32'd1);
        check_eq("to_cnt", n_to - t0, 32'd0);
        check_eq("end_busy", 32'(busy), 32'd0);
        check_eq("end_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    endtask

    initial begin
        int cnt_c, cnt_d, wf, pt, t0, d0, fall;
        logic [9:0] bits;
        logic [7:0] c;
        resetn       = 1'b0;
        command      = 8'h00;
        send_command = 1'b0;
        tick(3);
        check_eq("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check_eq("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_pulses", 32'({command_was_sent, error_timeout, error_no_ack}), 32'd0);
        resetn = 1'b1;
        tick(2);

        run_transfer(8'hED, 20, 1'b1, 1'b0);
        run_transfer(8'hF4, 16, 1'b1, 1'b0);
        run_transfer(8'hFF, 24, 1'b1, 1'b0);
        run_transfer(8'h00, 14, 1'b1, 1'b0);
        run_transfer(8'hED, 20, 1'b0, 1'b0);
        run_transfer(8'hED, 20, 1'b1, 1'b1);

        // Reset after the 4th data bit; bit 3 of 0x17 is 0 so data is being pulled low.
        start_send(8'h17);
        wait_release();
        tick(10);
        device_frame(20, 4, 1'b0, bits);
        check_eq("pre_rst_dat_oe", 32'(ps2_dat_oe), 32'd1);
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        resetn = 1'b0;
        tick(1);
        check_eq("midrst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        tick(2);
        run_transfer(8'hF4, 20, 1'b1, 1'b0);

        // Start timeout with no device clock; a request during the pulse cycle must be dropped.
        t0 = n_to; cnt_c = 0; cnt_d = 0; wf = -1; pt = -1;
        command      = 8'hA5;
        send_command = 1'b1;
        tick(1);
        send_command = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (ps2_clk_oe) cnt_c++;
            if (ps2_dat_oe) cnt_d++;
            if (!ps2_clk_oe && wf < 0) wf = cyc;
            if (error_timeout && pt < 0) begin
                pt           = cyc;
                command      = 8'h3C;
                send_command = 1'b1;
            end else begin
                send_command = 1'b0;
            end
            tick(1);
        end
        check_eq("inhibit_len", cnt_c, INH + 1);
        check_eq("dat_low_len", cnt_d, STO + 1);
        // STO waiting cycles, one released ERR_TO cycle, then the pulse.
        check_eq("start_to_delay", pt - wf, STO + 1);
        check_eq("start_to_cnt", n_to - t0, 32'd1);
        check_eq("start_to_oe", 32'({ps2_clk_oe, ps2_dat_oe, busy}), 32'd0);

        // Transfer timeout: device stops after 5 clocks.
        start_send(8'h96);
        wait_release();
        tick(10);
        t0 = n_to; d0 = n_done; fall = cyc; pt = -1;
        device_frame(20, 5, 1'b0, bits);
        for (int k = 0; k < XTO + 100 && pt < 0; k++) begin
            if (error_timeout) pt = cyc;
            else tick(1);
        end
        check_eq("xfer_to_window", 32'((pt - fall >= XTO) && (pt - fall <= XTO + 8)), 32'd1);
        tick(2);
        check_eq("xfer_to_cnt", n_to - t0, 32'd1);
        check_eq("xfer_to_done", n_done - d0, 32'd0);
        check_eq("xfer_to_oe", 32'({ps2_clk_oe, ps2_dat_oe, busy}), 32'd0);

        for (int r = 0; r < 8; r++) begin
            c = 8'($urandom_range(255, 0));
            run_transfer(c, int'($urandom_range(30, 12)), ($urandom_range(3, 0) != 0), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
